// File: rtl/cla_pkg.sv
// Carry-lookahead building blocks shared by the pipelined adder/subtractor.
// Purely combinational: zero latency.
// No flow control of its own; callers own the handshake.
package cla_pkg;

    localparam int CLA_GROUP_W = 4;

    // Generate/propagate pair of one lookahead group.
    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    // Result of one 4-wide lookahead: carry out of each position plus group G/P.
    typedef struct packed {
        logic [CLA_GROUP_W-1:0] c;
        logic                   gout;
        logic                   pout;
    } cla4_t;

    // c[i] is the carry out of position i; gout/pout summarise the whole group
    // independently of cin so the same function serves both lookahead levels.
    function automatic cla4_t cla_carries4(input logic [3:0] g,
                                           input logic [3:0] p,
                                           input logic       cin);
        cla4_t r;
        r.c[0] = g[0] | (p[0] & cin);
        r.c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        r.c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & cin);
        r.gout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0]);
        r.pout = &p;
        r.c[3] = r.gout | (r.pout & cin);
        return r;
    endfunction

endpackage

// File: rtl/cla_adder_pipe_if.sv
// Operand and result streams of the pipelined CLA adder/subtractor.
// No logic, no latency.
// in_valid/in_ready and out_valid/out_ready are independent valid/ready pairs.
interface cla_adder_pipe_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;

    // Producer of operands / consumer of results.
    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero
    );

    // The adder itself.
    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero
    );
endinterface

// File: rtl/cla_group4.sv
// One 4-bit lookahead group: bit carries plus group generate/propagate.
// Combinational, zero latency.
// No flow control; evaluated every cycle from the stage register it reads.
module cla_group4
    import cla_pkg::*;
(
    input  logic [3:0] g,
    input  logic [3:0] p,
    input  logic       cin,
    output logic [3:0] cout,
    output logic       gout,
    output logic       pout
);
    cla4_t res;

    assign res  = cla_carries4(g, p, cin);
    assign cout = res.c;
    assign gout = res.gout;
    assign pout = res.pout;
endmodule

// File: rtl/cla_adder_pipe.sv
// Two-level carry-lookahead adder/subtractor, WIDTH bits as WIDTH/4 groups.
// Latency 2 cycles from input acceptance to out_valid; 1 beat/cycle throughput.
// Elastic: a stalled output holds both stages; in_ready = !v1 || !v2 || out_ready.
module cla_adder_pipe
    import cla_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    cla_adder_pipe_if.slave bus
);
    localparam int GROUPS = WIDTH / CLA_GROUP_W;
    localparam int NCHUNK = (GROUPS + 3) / 4;

    if ((WIDTH % CLA_GROUP_W) != 0 || WIDTH < 4 || WIDTH > 64) begin : g_bad_width
        $error("cla_adder_pipe: WIDTH must be a multiple of 4 in the range 4..64");
    end

    // ---------------- handshake ----------------
    logic v1, v2;
    logic adv1, adv2;

    assign adv2          = !v2 || bus.out_ready;
    assign adv1          = !v1 || adv2;
    assign bus.in_ready  = adv1;
    assign bus.out_valid = v2;

    // ---------------- stage 1: bit and group generate/propagate ----------------
    logic [WIDTH-1:0]  b_eff, p_in, g_in;
    gp_t [GROUPS-1:0]  grp_in;
    logic              s1_c_unused;

    // Subtraction folds into the adder as a + ~b + 1; group G/P does not need carries.
    always_comb begin
        cla4_t r;
        r           = '0;
        b_eff       = bus.sub ? ~bus.b : bus.b;
        p_in        = bus.a ^ b_eff;
        g_in        = bus.a & b_eff;
        grp_in      = '0;
        s1_c_unused = 1'b0;
        for (int k = 0; k < GROUPS; k++) begin
            r            = cla_carries4(g_in[4*k +: 4], p_in[4*k +: 4], 1'b0);
            grp_in[k].g  = r.gout;
            grp_in[k].p  = r.pout;
            s1_c_unused ^= ^r.c;
        end
    end

    logic [WIDTH-1:0] p1, g1;
    gp_t [GROUPS-1:0] grp1;
    logic             c0_1, a_msb1, b_msb1;

    // Stage-1 occupancy: bubbles load as v1 = 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
        end else if (adv1) begin
            v1 <= bus.in_valid;
        end
    end

    // Stage-1 data loads only for a real beat so idle cycles do not toggle it.
    always_ff @(posedge clk) begin
        if (adv1 && bus.in_valid) begin
            p1     <= p_in;
            g1     <= g_in;
            grp1   <= grp_in;
            c0_1   <= bus.sub | bus.cin;
            a_msb1 <= bus.a[WIDTH-1];
            b_msb1 <= b_eff[WIDTH-1];
        end
    end

    // ---------------- stage 2: group carries, bit carries, flags ----------------
    logic [GROUPS-1:0] grp_cin;
    logic              la_unused;

    // Second-level lookahead: groups taken four at a time, chunks chained by carry.
    always_comb begin
        logic [4*NCHUNK-1:0] gg, pp;
        logic [4*NCHUNK:0]   cc;
        cla4_t               r;
        gg        = '0;
        pp        = '0;
        cc        = '0;
        r         = '0;
        la_unused = 1'b0;
        for (int k = 0; k < GROUPS; k++) begin
            gg[k] = grp1[k].g;
            pp[k] = grp1[k].p;
        end
        cc[0] = c0_1;
        for (int j = 0; j < NCHUNK; j++) begin
            r               = cla_carries4(gg[4*j +: 4], pp[4*j +: 4], cc[4*j]);
            cc[4*j+1 +: 4]  = r.c;
            la_unused      ^= r.gout ^ r.pout;
        end
        grp_cin    = cc[GROUPS-1:0];
        la_unused ^= ^cc[4*NCHUNK:GROUPS];
    end

    logic [WIDTH-1:0]  bit_cout;
    logic [GROUPS-1:0] grp_gout_unused, grp_pout_unused;

    for (genvar k = 0; k < GROUPS; k++) begin : g_grp
        cla_group4 u_grp (
            .g    (g1[4*k +: 4]),
            .p    (p1[4*k +: 4]),
            .cin  (grp_cin[k]),
            .cout (bit_cout[4*k +: 4]),
            .gout (grp_gout_unused[k]),
            .pout (grp_pout_unused[k])
        );
    end

    logic [WIDTH-1:0] carry_in, sum_nxt;
    logic             ovf_nxt;

    assign carry_in = {bit_cout[WIDTH-2:0], c0_1};
    assign sum_nxt  = p1 ^ carry_in;
    // Same-sign operands giving an opposite-sign result: equals carry-in ^ carry-out of the MSB.
    assign ovf_nxt  = (a_msb1 ~^ b_msb1) & (sum_nxt[WIDTH-1] ^ a_msb1);

    logic [WIDTH-1:0] sum_q;
    logic             cout_q, ovf_q, zero_q;

    // Stage-2 occupancy follows stage 1 whenever the output side can take it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2 <= 1'b0;
        end else if (adv2) begin
            v2 <= v1;
        end
    end

    // Result registers: held while stalled, loaded only from a valid stage 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (adv2 && v1) begin
            sum_q  <= sum_nxt;
            cout_q <= bit_cout[WIDTH-1];
            ovf_q  <= ovf_nxt;
            zero_q <= ~|sum_nxt;
        end
    end

    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
    assign bus.zero = zero_q;
endmodule

// File: tb/tb_cla_adder_pipe.sv
module tb_cla_adder_pipe;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;
    bit   rand_go  = 1'b0;

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } res_t;

    // Golden result straight from integer arithmetic on a w-bit word.
    function automatic res_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                   input logic cin, input logic sub);
        logic [64:0] mask, full;
        logic [63:0] bb;
        logic        c0;
        res_t        r;
        mask   = (65'd1 << w) - 65'd1;
        bb     = sub ? ~b : b;
        c0     = sub ? 1'b1 : cin;
        full   = ({1'b0, a} & mask) + ({1'b0, bb} & mask) + {64'd0, c0};
        r.sum  = full[63:0] & mask[63:0];
        r.cout = full[w];
        r.zero = (r.sum == 64'd0);
        r.ovf  = (a[w-1] == bb[w-1]) && (r.sum[w-1] != a[w-1]);
        return r;
    endfunction

    function automatic logic [63:0] pick(input int w);
        logic [63:0] m, v;
        m = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        case ($urandom_range(5))
            0:       v = '1;
            1:       v = 64'd1 << (w - 1);
            2:       v = 64'd0;
            default: v = {$urandom, $urandom};
        endcase
        return v & m;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- 32-bit instance: directed tests ----------------
    cla_adder_pipe_if #(.WIDTH(32)) d_if ();
    cla_adder_pipe #(.WIDTH(32)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(d_if));

    res_t q32[$];
    res_t hold32;
    bit   stall32 = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            q32.delete();
            stall32 = 1'b0;
        end else begin
            if (stall32) begin
                chk("w32_hold_valid", 64'(d_if.out_valid), 64'd1);
                chk("w32_hold_sum", 64'(d_if.sum), hold32.sum);
            end
            if (d_if.out_valid) begin
                if (q32.size() == 0) begin
                    chk("w32_spurious_beat", 64'(d_if.out_valid), 64'd0);
                end else begin
                    chk("w32_sum", 64'(d_if.sum), q32[0].sum);
                    chk("w32_cout", 64'(d_if.cout), 64'(q32[0].cout));
                    chk("w32_ovf", 64'(d_if.ovf), 64'(q32[0].ovf));
                    chk("w32_zero", 64'(d_if.zero), 64'(q32[0].zero));
                    if (d_if.out_ready) void'(q32.pop_front());
                end
            end
            stall32 = d_if.out_valid && !d_if.out_ready;
            hold32  = '{sum: 64'(d_if.sum), cout: d_if.cout, ovf: d_if.ovf, zero: d_if.zero};
            if (d_if.in_valid && d_if.in_ready)
                q32.push_back(model(32, 64'(d_if.a), 64'(d_if.b), d_if.cin, d_if.sub));
        end
    end

    // ---------------- random regression at 4, 16 and 64 bits ----------------
    for (genvar gi = 0; gi < 3; gi++) begin : g_rand
        localparam int W = (gi == 0) ? 4 : ((gi == 1) ? 16 : 64);
        cla_adder_pipe_if #(.WIDTH(W)) r_if ();
        cla_adder_pipe #(.WIDTH(W)) u_dut (.clk(clk), .rst_n(rst_n), .bus(r_if));

        res_t q[$];
        res_t hold;
        bit   stall = 1'b0;
        bit   done  = 1'b0;
        int   nout  = 0;

        always @(negedge clk) begin
            if (!rst_n) begin
                q.delete();
                stall = 1'b0;
            end else begin
                if (stall) begin
                    chk($sformatf("w%0d_hold_valid", W), 64'(r_if.out_valid), 64'd1);
                    chk($sformatf("w%0d_hold_sum", W), 64'(r_if.sum), hold.sum);
                end
                if (r_if.out_valid) begin
                    if (q.size() == 0) begin
                        chk($sformatf("w%0d_spurious_beat", W), 64'(r_if.out_valid), 64'd0);
                    end else begin
                        chk($sformatf("w%0d_sum", W), 64'(r_if.sum), q[0].sum);
                        chk($sformatf("w%0d_cout", W), 64'(r_if.cout), 64'(q[0].cout));
                        chk($sformatf("w%0d_ovf", W), 64'(r_if.ovf), 64'(q[0].ovf));
                        chk($sformatf("w%0d_zero", W), 64'(r_if.zero), 64'(q[0].zero));
                        if (r_if.out_ready) begin
                            void'(q.pop_front());
                            nout++;
                        end
                    end
                end
                stall = r_if.out_valid && !r_if.out_ready;
                hold  = '{sum: 64'(r_if.sum), cout: r_if.cout, ovf: r_if.ovf, zero: r_if.zero};
                if (r_if.in_valid && r_if.in_ready)
                    q.push_back(model(W, 64'(r_if.a), 64'(r_if.b), r_if.cin, r_if.sub));
            end
        end

        initial begin
            r_if.in_valid  = 1'b0;
            r_if.a         = '0;
            r_if.b         = '0;
            r_if.cin       = 1'b0;
            r_if.sub       = 1'b0;
            r_if.out_ready = 1'b1;
            wait (rand_go);
            repeat (800) begin
                @(posedge clk);
                #1;
                r_if.in_valid  = ($urandom_range(3) != 0);
                r_if.a         = W'(pick(W));
                r_if.b         = W'(pick(W));
                r_if.cin       = 1'($urandom_range(1));
                r_if.sub       = 1'($urandom_range(1));
                r_if.out_ready = ($urandom_range(2) != 0);
            end
            @(posedge clk);
            #1;
            r_if.in_valid  = 1'b0;
            r_if.out_ready = 1'b1;
            repeat (6) @(negedge clk);
            #1;
            chk($sformatf("w%0d_drained", W), 64'(q.size()), 64'd0);
            chk($sformatf("w%0d_beats_seen", W), 64'(nout > 100), 64'd1);
            done = 1'b1;
        end
    end

    // ---------------- directed helpers ----------------
    task automatic drive32(input logic v, input logic [31:0] a, input logic [31:0] b,
                           input logic cin, input logic sub, input logic rdy);
        d_if.in_valid  = v;
        d_if.a         = a;
        d_if.b         = b;
        d_if.cin       = cin;
        d_if.sub       = sub;
        d_if.out_ready = rdy;
    endtask

    task automatic run_one(input string nm, input logic [31:0] a, input logic [31:0] b,
                           input logic cin, input logic sub, input logic [31:0] es,
                           input logic ec, input logic eo, input logic ez);
        @(posedge clk);
        #1;
        drive32(1'b1, a, b, cin, sub, 1'b1);
        @(posedge clk);
        #1;
        d_if.in_valid = 1'b0;
        @(negedge clk);
        chk({nm, "_lat1_valid"}, 64'(d_if.out_valid), 64'd0);
        @(negedge clk);
        chk({nm, "_lat2_valid"}, 64'(d_if.out_valid), 64'd1);
        chk({nm, "_sum"}, 64'(d_if.sum), 64'(es));
        chk({nm, "_cout"}, 64'(d_if.cout), 64'(ec));
        chk({nm, "_ovf"}, 64'(d_if.ovf), 64'(eo));
        chk({nm, "_zero"}, 64'(d_if.zero), 64'(ez));
    endtask

    initial begin
        res_t m;
        int   sent, recv;

        rst_n = 1'b0;
        drive32(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);

        // Reset state, observed after a clock edge under reset.
        @(negedge clk);
        chk("rst_out_valid", 64'(d_if.out_valid), 64'd0);
        chk("rst_sum", 64'(d_if.sum), 64'd0);
        chk("rst_flags", 64'({d_if.cout, d_if.ovf, d_if.zero}), 64'd0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 64'(d_if.in_ready), 64'd1);

        // Pin the model itself to hand-computed values.
        m = model(32, 64'hFFFF_FFFF, 64'h1, 1'b0, 1'b0);
        chk("model_wrap_sum", m.sum, 64'd0);
        chk("model_wrap_flags", 64'({m.cout, m.ovf, m.zero}), 64'b101);
        m = model(32, 64'h8000_0000, 64'h1, 1'b0, 1'b1);
        chk("model_subovf_sum", m.sum, 64'h7FFF_FFFF);
        chk("model_subovf_flags", 64'({m.cout, m.ovf, m.zero}), 64'b110);
        m = model(4, 64'h7, 64'h1, 1'b0, 1'b0);
        chk("model_w4_ovf", 64'({m.sum[3:0], m.cout, m.ovf}), 64'b1000_01);

        // Single beats with literal expectations and latency.
        run_one("add_wrap", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        run_one("sub_ovf", 32'h8000_0000, 32'h1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
        run_one("sub_borrow", 32'h5, 32'h7, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        run_one("add_cin", 32'h7FFF_FFFF, 32'h0, 1'b1, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);

        // Back-to-back stream: a=i, b=i, cin=1 -> outputs on cycles 2..9.
        @(posedge clk);
        for (int cyc = 0; cyc < 12; cyc++) begin
            #1;
            if (cyc < 8) drive32(1'b1, 32'(cyc), 32'(cyc), 1'b1, 1'b0, 1'b1);
            else         d_if.in_valid = 1'b0;
            @(negedge clk);
            chk($sformatf("stream_in_ready_c%0d", cyc), 64'(d_if.in_ready), 64'd1);
            chk($sformatf("stream_valid_c%0d", cyc), 64'(d_if.out_valid),
                64'(cyc >= 2 && cyc <= 9));
            if (cyc >= 2 && cyc <= 9)
                chk($sformatf("stream_sum_c%0d", cyc), 64'(d_if.sum), 64'(2 * (cyc - 2) + 1));
            @(posedge clk);
        end

        // Backpressure: out_ready low for 5 cycles while six beats are offered.
        sent = 0;
        recv = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            #1;
            drive32(sent < 6, 32'h1000 * 32'(sent) + 32'd7, 32'(sent), 1'b0, 1'b0, cyc >= 5);
            @(negedge clk);
            if (cyc >= 2 && cyc <= 4) begin
                chk($sformatf("stall_in_ready_c%0d", cyc), 64'(d_if.in_ready), 64'd0);
                chk($sformatf("stall_accepted_c%0d", cyc), 64'(sent), 64'd2);
                chk($sformatf("stall_sum_c%0d", cyc), 64'(d_if.sum), 64'd7);
            end
            if (d_if.out_valid && d_if.out_ready) begin
                chk($sformatf("stall_order_%0d", recv), 64'(d_if.sum),
                    64'(32'h1001 * 32'(recv) + 32'd7));
                recv++;
            end
            if (d_if.in_valid && d_if.in_ready) sent++;
            @(posedge clk);
        end
        chk("stall_sent", 64'(sent), 64'd6);
        chk("stall_recv", 64'(recv), 64'd6);

        // Asynchronous reset with both stages full.
        #1;
        drive32(1'b1, 32'd1, 32'd2, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        d_if.a = 32'd3;
        @(posedge clk);
        #1;
        d_if.in_valid = 1'b0;
        chk("full_in_ready", 64'(d_if.in_ready), 64'd0);
        chk("full_out_valid", 64'(d_if.out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(d_if.out_valid), 64'd0);
        chk("arst_sum", 64'(d_if.sum), 64'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        d_if.out_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 64'(d_if.in_ready), 64'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("post_rst_no_stale_%0d", i), 64'(d_if.out_valid), 64'd0);
        end

        // Random regression on the other widths, bounded in time.
        rand_go = 1'b1;
        fork
            wait (g_rand[0].done && g_rand[1].done && g_rand[2].done);
            repeat (5000) @(posedge clk);
        join_any
        disable fork;
        chk("rand_complete", 64'(g_rand[0].done && g_rand[1].done && g_rand[2].done), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cla_adder_pipe.md
Name: cla_adder_pipe

Overview:
- Parametrised two-level carry-lookahead adder/subtractor with a 2-stage elastic pipeline and valid/ready handshakes on input and output.
- Successor to the fixed 4-bit lookahead generator: width is generalised to WIDTH bits as WIDTH/4 groups of 4 bits.
- Group lookahead produces in-group carries plus group generate/propagate (gout/pout); a second-level lookahead computes the group carry-ins.
- Used by the pipelined ALU and by address/branch-target adders, which need a throughput of one operation per cycle under backpressure.

Parameters:
WIDTH, 32, operand width; must be a multiple of 4 and in the range 4..64; elaboration error otherwise
GROUPS, WIDTH/4, derived local parameter; not overridable

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand beat valid
in_ready  out  1  block accepts a beat this cycle
a  in  WIDTH  operand A
b  in  WIDTH  operand B
cin  in  1  carry-in, used for add only
sub  in  1  0 = a+b+cin; 1 = a-b (a + ~b + 1; cin ignored)
out_valid  out  1  result beat valid
out_ready  in  1  consumer accepts the result beat
sum  out  WIDTH  result
cout  out  1  carry out of bit WIDTH-1 (for sub: 1 means no borrow)
ovf  out  1  signed overflow = carry into MSB XOR carry out of MSB
zero  out  1  sum == 0

Behaviour:
- Handshake: a transfer occurs when valid && ready on the same rising edge. in_ready is combinational from pipeline state and out_ready, with no dependence on in_valid. out_valid does not depend combinationally on out_ready. Once out_valid is high, sum/cout/ovf/zero are held stable until the beat is accepted.
- Stage 1 (S1 register, valid bit v1):
  - Capture per-bit p = a^b', g = a&b' (b' = sub ? ~b : b), effective carry-in c0 = sub ? 1 : cin, and per-group G/P from the group lookahead.
  - Also capture the MSB values of a and b'.
- Stage 2 (S2 register, valid bit v2):
  - Second-level lookahead over the GROUPS G/P pairs plus c0 gives the carry-in of each group.
  - Each group's lookahead gives the bit carries.
  - sum = p ^ carries; cout = carry out of the top group.
  - ovf and zero are computed in S2 and registered with sum.
- Latency: exactly 2 cycles from input acceptance to out_valid when there is no stall. Throughput is 1 beat/cycle.
- Advance rules:
  - adv2 = !v2 || out_ready
  - adv1 = !v1 || adv2
  - in_ready = adv1
  - S2 loads from S1 when adv2; v2 <= v1 on that load.
  - S1 loads inputs when adv1; v1 <= in_valid on that load.
  - Stalled stages hold their contents.
- Full pipeline with out_ready = 0: v1 = v2 = 1, in_ready = 0, no beat lost or duplicated.
- Simultaneous accept and emit at full occupancy: the pipeline shifts by one and in_ready stays 1.
- Empty bubbles (in_valid = 0) propagate as v = 0. Datapath registers update only on a load with valid = 1 (clock-gating friendly).
- Reset (asynchronous assert, synchronous deassert handled externally):
  - v1 = v2 = 0, out_valid = 0; sum = 0, cout = 0, ovf = 0, zero = 0.
  - Reset mid-operation discards all in-flight beats.
  - in_ready is 1 in the first cycle after reset.
- Arithmetic wraps modulo 2^WIDTH. No saturation.

Decomposition:
- Package cla_pkg: typedef gp_t (struct g, p), constant CLA_GROUP_W = 4, function cla_carries4(g, p, cin) returning the 4 carries plus gout/pout.
- Sub-module cla_group4: 4-bit g/p/cin in; cout[3:0], gout, pout out.
  - Instantiated GROUPS times in S2 for bit carries.
  - Stage 1 and the second-level lookahead reuse the package function.

Test Plan:
- WIDTH=32, add, a=32'hFFFF_FFFF, b=32'h1, cin=0 -> after 2 cycles sum=0, cout=1, zero=1, ovf=0.
- sub, a=32'h8000_0000, b=32'h1 -> sum=32'h7FFF_FFFF, ovf=1, cout=1; sub, a=5, b=7 -> sum=32'hFFFF_FFFE, cout=0 (borrow).
- Stream 8 back-to-back beats (a=i, b=i, cin=1) with out_ready=1 -> out_valid high on cycles 2..9, sums 1,3,5,...,15 in order.
- out_ready=0 for 5 cycles during a stream -> in_ready drops after 2 accepted beats, outputs held stable; on release, all beats emerge in order with none lost or duplicated.
- Assert rst_n=0 with v1=v2=1 -> out_valid=0 and sum=0 immediately (asynchronous); after release in_ready=1 and no stale beat appears.
- Random regression at WIDTH=4, 16 and 64 against a golden a+b'+c0 model, checking sum, cout, ovf and zero.
